alu_ex_stage: RTL
=================

Name: alu_ex_stage

Overview:
- Execute stage sitting directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus two 32-bit operands, computes the result and flags, and registers them into the EX/MEM boundary.
- Uses a valid/ready handshake so MEM-side stalls back-pressure into ID.
- Carries destination-register metadata alongside the result.

Parameters:
- XLEN, 32, operand/result width.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and control code valid this cycle.
- in_ready  output  1  stage can accept a new operation.
- alu_ctrl  input  4  operation code from ALU control decoder (ADD/SUB/AND/OR/ERR).
- op_a  input  XLEN  operand A (rs1).
- op_b  input  XLEN  operand B (rs2 or immediate).
- in_rd  input  RD_W  destination register index.
- in_regwrite  input  1  writeback enable for this op.
- flush  input  1  synchronous kill of held result (branch redirect).
- out_valid  output  1  registered result valid.
- out_ready  input  1  MEM stage accepts result.
- result  output  XLEN  registered ALU result.
- zero  output  1  result == 0 (used for BEQ/BNE).
- ovf  output  1  signed overflow, ADD/SUB only.
- err  output  1  alu_ctrl was ERR or unknown.
- out_rd  output  RD_W  registered in_rd.
- out_regwrite  output  1  registered in_regwrite, forced 0 on err.
- err_status  output  1  sticky error (see Optional Feature).
- err_clr  input  1  clears err_status.

Behaviour:
- Reset (rst_n low, async): out_valid=0, result=0, zero=0, ovf=0, err=0, out_rd=0, out_regwrite=0, err_status=0.
- in_ready = !out_valid || out_ready (combinational; no input-to-output combinational path other than out_ready->in_ready).
- Accept when in_valid && in_ready; the registered outputs update on that edge. Latency is exactly 1 cycle.
- Hold when out_valid && !out_ready: all outputs stable, in_ready=0.
- Drain when out_valid && out_ready && !in_valid: out_valid->0 next cycle; data outputs may keep their old values.
- Back-to-back: full throughput of 1 op/cycle while out_ready=1.
- Operations:
  - ADD: a+b mod 2^XLEN. ovf = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB: a-b mod 2^XLEN. ovf = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - AND, OR: bitwise; ovf=0.
  - ERR or any unlisted code: result=0, zero=1, ovf=0, err=1, out_regwrite=0.
- zero is computed from the final result in every case.
- Flush:
  - flush=1 forces out_valid=0 next edge and blocks capture that cycle, regardless of in_valid or out_ready.
  - in_ready is still driven by the formula; an op offered during flush is dropped by design, and upstream squashes it.
- Simultaneous flush and accept: flush wins, out_valid=0.
- Reset mid-hold: all state cleared immediately; no result replayed after reset release.

Optional Feature:
- Macro ALU_ERR_STICKY_EN.
- Defined: err_status sets on the edge that captures an op with err=1 and stays set until err_clr=1. If set and clear coincide, set wins.
- Undefined: err_status tied 0 and err_clr ignored. All other behaviour is identical.

Decomposition:
- Shared parameters header holds the ALU control encodings: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_ERR=4'b1111. Also XLEN.
- One natural sub-module, alu_core: purely combinational, alu_ctrl/op_a/op_b -> result/zero/ovf/err.
- alu_ex_stage holds the handshake register, flush and sticky-error logic.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle result=0x80000000, ovf=1, zero=0, out_valid=1.
- SUB 0x00000005-0x00000005 -> result=0, zero=1, ovf=0. Then SUB 0x80000000-0x00000001 -> result=0x7FFFFFFF, ovf=1.
- AND/OR with 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 and 0xFFF0FFF0.
- Back-pressure: 3 back-to-back ops with out_ready=0 for 2 cycles after the first capture -> first result held stable, in_ready=0, no op lost or duplicated, remaining ops emerge in order.
- alu_ctrl=4'b1111 with in_regwrite=1 -> err=1, result=0, out_regwrite=0. With ALU_ERR_STICKY_EN defined, err_status=1 until err_clr pulses.
- flush asserted together with a valid ADD -> out_valid=0 next cycle. Async rst_n pulse mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_ex_stage_pkg.sv
// rtl/alu_ex_stage_pkg.sv - shared widths and ALU control encodings for the EX stage
package alu_ex_stage_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_ERR = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu_ex_stage_alu_core.sv
// rtl/alu_ex_stage_alu_core.sv - combinational ALU: control code and operands to result and flags
module alu_core
  import alu_ex_stage_pkg::*;
#(
  parameter int XLEN = alu_ex_stage_pkg::XLEN
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            ovf,
  output logic            err
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;

  assign w_sum  = op_a + op_b;
  assign w_diff = op_a - op_b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        result = w_sum;
        ovf    = (op_a[XLEN-1] == op_b[XLEN-1]) && (w_sum[XLEN-1] != op_a[XLEN-1]);
      end
      ALU_SUB: begin
        result = w_diff;
        ovf    = (op_a[XLEN-1] != op_b[XLEN-1]) && (w_diff[XLEN-1] != op_a[XLEN-1]);
      end
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      // ALU_ERR and every unlisted code land here
      default: err = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - EX stage with valid/ready output register, flush and optional sticky error (ALU_ERR_STICKY_EN)
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int XLEN = alu_ex_stage_pkg::XLEN,
  parameter int RD_W = alu_ex_stage_pkg::RD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_regwrite,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            ovf,
  output logic            err,
  output logic [RD_W-1:0] out_rd,
  output logic            out_regwrite,
  output logic            err_status,
  input  logic            err_clr
);

  logic [XLEN-1:0] w_result;
  logic            w_zero;
  logic            w_ovf;
  logic            w_err;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_ovf;
  logic            r_err;
  logic [RD_W-1:0] r_rd;
  logic            r_regwrite;

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (w_result),
    .zero     (w_zero),
    .ovf      (w_ovf),
    .err      (w_err)
  );

  assign in_ready = !r_valid || out_ready;
  // An op offered while flushing is dropped; upstream squashes it too
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_result   <= w_result;
      r_zero     <= w_zero;
      r_ovf      <= w_ovf;
      r_err      <= w_err;
      r_rd       <= in_rd;
      r_regwrite <= in_regwrite && !w_err;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef ALU_ERR_STICKY_EN
  logic r_err_status;

  // Set has priority over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_status <= 1'b0;
    end else if (w_accept && w_err) begin
      r_err_status <= 1'b1;
    end else if (err_clr) begin
      r_err_status <= 1'b0;
    end
  end

  assign err_status = r_err_status;
`else
  assign err_status = err_clr & 1'b0;
`endif

  assign out_valid    = r_valid;
  assign result       = r_result;
  assign zero         = r_zero;
  assign ovf          = r_ovf;
  assign err          = r_err;
  assign out_rd       = r_rd;
  assign out_regwrite = r_regwrite;

endmodule
